apb_timer: RTL

//  APB slave timer on the bridge's timer port; consumes timer_addr, timer_enable (PSEL), penable, write_enable.
//  32-bit down-counter with prescaler, one-shot/auto-reload modes, sticky expiry flag and level interrupt to the MIPS core.

---
 rtl/timer_pkg.sv | 25 ++
 rtl/timer_prescaler.sv | 34 +++
 rtl/apb_timer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | timer_pkg                                                                |
// | Register offsets, CTRL/STATUS bit positions and reset values for the     |
// | APB timer.                                                               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package timer_pkg;

  localparam logic [7:0] c_off_ctrl   = 8'h00;
  localparam logic [7:0] c_off_load   = 8'h04;
  localparam logic [7:0] c_off_count  = 8'h08;
  localparam logic [7:0] c_off_presc  = 8'h0C;
  localparam logic [7:0] c_off_status = 8'h10;
  localparam logic [7:0] c_off_cmp    = 8'h14;

  localparam int c_bit_en  = 0;
  localparam int c_bit_ar  = 1;
  localparam int c_bit_ie  = 2;
  localparam int c_bit_exp = 0;

  localparam logic [31:0] c_load_rst = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | timer_prescaler                                                          |
// | Divides the clock: tick fires once every presc+1 enabled clocks.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module timer_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               restart,
  output logic               tick
);

  logic [PRESC_W-1:0] r_cnt;

  // Exact match: a PRESC lowered below the running count waits for wrap-around.
  assign tick = en && (r_cnt == presc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!en || restart || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PRESC_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apb_timer                                                                |
// | Zero-wait-state APB slave: 32-bit prescaled down-counter, one-shot or    |
// | auto-reload, sticky expiry flag and level irq. Optional compare output   |
// | enabled by defining TIMER_PWM_EN.                                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module apb_timer
  import timer_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int PRESC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              irq,
  output logic              pwm_out
);

  logic               r_en, r_ar, r_ie, r_exp;
  logic [DATA_W-1:0]  r_load, r_count;
  logic [PRESC_W-1:0] r_presc;

  logic               w_access, w_wr, w_tick, w_expire, w_restart;
  logic               w_wr_ctrl, w_wr_load, w_wr_presc, w_wr_status;
  logic               w_mapped, w_ro_err;
  logic [ADDR_W-1:0]  w_off;
  logic [DATA_W-1:0]  w_rdata;
  logic               w_unused_ok;

  assign w_off       = {paddr[ADDR_W-1:2], 2'b00};
  assign w_unused_ok = ^paddr[1:0];

  // Reset suppresses the response so an aborted transfer never completes.
  assign w_access    = psel && penable && !rst;
  assign w_wr        = w_access && pwrite;
  assign w_wr_ctrl   = w_wr && (w_off == ADDR_W'(c_off_ctrl));
  assign w_wr_load   = w_wr && (w_off == ADDR_W'(c_off_load));
  assign w_wr_presc  = w_wr && (w_off == ADDR_W'(c_off_presc));
  assign w_wr_status = w_wr && (w_off == ADDR_W'(c_off_status));
  assign w_ro_err    = pwrite && (w_off == ADDR_W'(c_off_count));
  assign w_restart   = w_wr_ctrl && pwdata[c_bit_en] && !r_en;

  timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk     (clk),
    .rst     (rst),
    .en      (r_en),
    .presc   (r_presc),
    .restart (w_restart),
    .tick    (w_tick)
  );

  assign w_expire = w_tick && (r_count == '0);

`ifdef TIMER_PWM_EN
  logic [DATA_W-1:0] r_cmp;
  logic              w_wr_cmp;

  assign w_wr_cmp = w_wr && (w_off == ADDR_W'(c_off_cmp));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmp   <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (w_wr_cmp) r_cmp <= pwdata;
      pwm_out <= r_en && (r_count < r_cmp);
    end
  end
`else
  assign pwm_out = 1'b0;
`endif

  always_comb begin
    w_rdata  = '0;
    w_mapped = 1'b1;
    if (w_off == ADDR_W'(c_off_ctrl))        w_rdata = DATA_W'({r_ie, r_ar, r_en});
    else if (w_off == ADDR_W'(c_off_load))   w_rdata = r_load;
    else if (w_off == ADDR_W'(c_off_count))  w_rdata = r_count;
    else if (w_off == ADDR_W'(c_off_presc))  w_rdata = DATA_W'(r_presc);
    else if (w_off == ADDR_W'(c_off_status)) w_rdata = DATA_W'(r_exp);
`ifdef TIMER_PWM_EN
    else if (w_off == ADDR_W'(c_off_cmp))    w_rdata = r_cmp;
`endif
    else                                     w_mapped = 1'b0;
  end

  assign pready  = w_access;
  assign pslverr = w_access && (!w_mapped || w_ro_err);
  assign prdata  = (w_access && !pwrite) ? w_rdata : '0;
  assign irq     = r_exp && r_ie;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en    <= 1'b0;
      r_ar    <= 1'b0;
      r_ie    <= 1'b0;
      r_exp   <= 1'b0;
      r_load  <= DATA_W'(c_load_rst);
      r_count <= '0;
      r_presc <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_en <= pwdata[c_bit_en];
        r_ar <= pwdata[c_bit_ar];
        r_ie <= pwdata[c_bit_ie];
        if (w_restart) r_count <= r_load;
      end
      if (w_wr_load)  r_load  <= pwdata;
      if (w_wr_presc) r_presc <= pwdata[PRESC_W-1:0];
      if (w_wr_status && pwdata[c_bit_exp]) r_exp <= 1'b0;
      // Tick effects come last so expiry wins over W1C and over a CTRL write.
      if (w_tick) begin
        if (!w_expire) begin
          r_count <= r_count - DATA_W'(1);
        end else begin
          r_exp <= 1'b1;
          if (r_ar) r_count <= r_load;
          else      r_en    <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire
